output_spike_accum: RTL and testbench
=====================================

// Module: output_spike_accum
// PURPOSE
//  Clocked, parametrised output memory for the SNN conv layer. Collects NoC psum writes
//  (ts, addr, value) for NUM_TS timesteps into per-timestep banks. Once every bank is full,
//  runs leaky integrate-and-fire over each timestep in order and streams spikes to the
//  result sink. The membrane residue carries from timestep to timestep within a frame.
//  Sits between the NoC depacketizer/arbiter and the spike result channel.
// PARAMETERS
//  DEPTH      441  neurons per timestep (output feature-map size)
//  ADDR_W     9    address width, 2**ADDR_W >= DEPTH
//  NUM_TS     2    timesteps per frame (>=1)
//  TS_W       1    timestep index width, 2**TS_W >= NUM_TS
//  PSUM_W     13   psum width, unsigned
//  RES_W      14   residue/membrane width, >= PSUM_W+1
//  THRESHOLD  64   fire when membrane > THRESHOLD (strictly greater)
//  RESET_MODE 0    0: subtract THRESHOLD on fire; 1: reset membrane to 0 on fire
//  LEAK_SHIFT 0    0: no leak; k>0: membrane -= membrane>>k before adding psum
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  in_valid   in   1       psum write valid
//  in_ready   out  1       high only in COLLECT
//  in_ts      in   TS_W    timestep index of psum
//  in_addr    in   ADDR_W  neuron address
//  in_psum    in   PSUM_W  psum value
//  spk_valid  out  1       spike result valid
//  spk_ready  in   1       sink ready
//  spk_data   out  1       1 = fired
//  spk_addr   out  ADDR_W  neuron address of result
//  spk_ts     out  TS_W    timestep of result
//  frame_done out  1       1-cycle pulse after the last result of a frame is accepted
//  err_oor    out  1       sticky: out-of-range ts/addr seen; cleared only by reset
// BEHAVIOUR
//  Reset (async): state=COLLECT; all outputs 0 except in_ready=1; fill bitmaps, counters
//   and residue memory cleared. Reset mid-frame discards all partial data.
//  Handshakes are valid/ready, transfer on the rising edge with both high. spk_* stay
//   stable while spk_valid=1 and spk_ready=0.
//  COLLECT: psum_mem[in_ts][in_addr] <= in_psum. A per-(ts,addr) fill bit is set; cnt[ts]
//   increments only on the first write to an entry. A duplicate write overwrites the
//   data without counting. in_ts>=NUM_TS or in_addr>=DEPTH: accepted, dropped, err_oor<=1.
//   When every cnt==DEPTH (checked after the update, so it can happen on the same accepting
//   edge) -> FIRE next cycle with ts=0, addr=0. in_ready drops on the cycle after that edge.
//  FIRE: per element, m = res[addr] - (LEAK_SHIFT ? res[addr]>>LEAK_SHIFT : 0)
//   + psum_mem[ts][addr], computed in RES_W+1 bits and saturated to 2**RES_W-1.
//   fire = m > THRESHOLD. new_res = fire ? (RESET_MODE ? 0 : m-THRESHOLD) : m.
//   The result is registered, so spk_valid rises 1 cycle after FIRE entry. res[addr] is
//   written only on the spk handshake. Throughput is 1 result/cycle with spk_ready held high.
//   addr wraps DEPTH-1 -> 0 and ts increments. After the handshake at (NUM_TS-1, DEPTH-1)
//   -> DONE.
//  DONE (1 cycle): frame_done=1; residue memory, fill bits and counters cleared (a new frame
//   starts with membrane 0) -> COLLECT.
//  Order is fixed: ts ascending, addr ascending within ts; exactly NUM_TS*DEPTH results per frame.
//  in_valid while not COLLECT: held off (in_ready=0), no side effects.
// TESTING
//  T1 DEPTH=4,NUM_TS=2: ts0 psum=70 all, ts1 psum=10 all -> ts0 spk=1 (res 6), ts1 spk=0
//     (m=16); frame_done once.
//  T2 RESET_MODE=1: ts0 psum=100, ts1 psum=60 -> ts0 fire (res 0), ts1 m=60 no fire.
//  T3 LEAK_SHIFT=1: ts0 psum=40, ts1 psum=50 -> ts1 m=20+50=70 -> spk=1; with LEAK_SHIFT=0
//     m=90 -> spk=1, res 26.
//  T4 duplicate addr 2 in ts0 (5 then 80), all others 0 -> FIRE waits for the full count;
//     addr2 uses 80 -> spk=1.
//  T5 spk_ready toggled randomly -> outputs stable while stalled, no result lost/duplicated;
//     in_addr=DEPTH -> err_oor=1, no fill.
//  T6 rst_n low mid-FIRE -> all outputs 0, in_ready=1; next full frame matches golden model
//     from zero residue.

Source files
------------

// File: rtl/output_spike_accum.sv
// Output memory for the SNN conv layer: gathers per-timestep psums from the NoC, then runs
// leaky integrate-and-fire over every timestep in order and streams one spike per neuron.
module output_spike_accum #(
  parameter int DEPTH      = 441,
  parameter int ADDR_W     = 9,
  parameter int NUM_TS     = 2,
  parameter int TS_W       = 1,
  parameter int PSUM_W     = 13,
  parameter int RES_W      = 14,
  parameter int THRESHOLD  = 64,
  parameter int RESET_MODE = 0,
  parameter int LEAK_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TS_W-1:0]   in_ts,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic              spk_data,
  output logic [ADDR_W-1:0] spk_addr,
  output logic [TS_W-1:0]   spk_ts,
  output logic              frame_done,
  output logic              err_oor
);

  localparam int NUM_ENT = NUM_TS * DEPTH;
  localparam int IDX_W   = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
  localparam int RA_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FIRE    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [RES_W-1:0] THR     = RES_W'(THRESHOLD);
  localparam logic [RES_W-1:0] RES_MAX = '1;

  logic [1:0]        r_state;
  logic [PSUM_W-1:0] r_psum_mem [NUM_ENT];
  logic [RES_W-1:0]  r_res_mem  [DEPTH];
  logic [NUM_ENT-1:0] r_fill;
  logic [DEPTH-1:0]  r_res_vld;
  logic              r_err_oor;

  logic [TS_W-1:0]   r_ts;
  logic [ADDR_W-1:0] r_addr;
  logic              r_issued_all;

  logic              r_spk_valid;
  logic              r_spk_data;
  logic [ADDR_W-1:0] r_spk_addr;
  logic [TS_W-1:0]   r_spk_ts;
  logic [RES_W-1:0]  r_spk_res;

  // ---------------------------------------------------------------- collect side
  logic              w_accept;
  logic              w_oor;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_first;
  logic [NUM_TS-1:0] w_ts_full;
  logic              w_all_full;

  assign w_accept = in_valid && (r_state == ST_COLLECT);
  assign w_oor    = (32'(in_ts) >= NUM_TS) || (32'(in_addr) >= DEPTH);
  assign w_wr_en  = w_accept && !w_oor;
  assign w_wr_idx = IDX_W'(32'(in_ts) * DEPTH + 32'(in_addr));
  assign w_first  = w_wr_en && !r_fill[w_wr_idx];

  // Per-timestep fill counters; fullness is judged on the post-update value so the
  // completing write itself can launch FIRE.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TS; gi++) begin : g_cnt
      logic             w_inc;
      logic [CNT_W-1:0] w_cnt_next;
      logic [CNT_W-1:0] r_cnt;

      assign w_inc          = w_first && (32'(in_ts) == gi);
      assign w_cnt_next     = r_cnt + CNT_W'(w_inc);
      assign w_ts_full[gi]  = (w_cnt_next == CNT_W'(DEPTH));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (r_state == ST_DONE) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end
    end
  endgenerate

  assign w_all_full = &w_ts_full;

  // ---------------------------------------------------------------- fire datapath
  logic              w_hs;
  logic              w_slot_free;
  logic              w_issue;
  logic              w_last_ptr;
  logic              w_last_hs;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [PSUM_W-1:0] w_psum_rd;
  logic [RES_W-1:0]  w_res_cur;
  logic [RES_W-1:0]  w_leak;
  logic [RES_W:0]    w_m_wide;
  logic [RES_W-1:0]  w_m;
  logic              w_fire;
  logic [RES_W-1:0]  w_new_res;

  assign w_hs        = r_spk_valid && spk_ready;
  assign w_slot_free = !r_spk_valid || spk_ready;
  assign w_issue     = (r_state == ST_FIRE) && !r_issued_all && w_slot_free;
  assign w_last_ptr  = (32'(r_ts) == NUM_TS - 1) && (32'(r_addr) == DEPTH - 1);
  assign w_last_hs   = w_hs && (32'(r_spk_ts) == NUM_TS - 1) && (32'(r_spk_addr) == DEPTH - 1);

  assign w_rd_idx  = IDX_W'(32'(r_ts) * DEPTH + 32'(r_addr));
  assign w_psum_rd = r_psum_mem[w_rd_idx];

  // The residue being committed this cycle is forwarded so a one-neuron layer still
  // sees the value from the previous timestep.
  always_comb begin
    w_res_cur = '0;
    if (w_hs && (r_spk_addr == r_addr)) begin
      w_res_cur = r_spk_res;
    end else if (r_res_vld[RA_W'(r_addr)]) begin
      w_res_cur = r_res_mem[RA_W'(r_addr)];
    end
  end

  assign w_leak    = (LEAK_SHIFT > 0) ? (w_res_cur >> LEAK_SHIFT) : '0;
  assign w_m_wide  = {1'b0, w_res_cur} - {1'b0, w_leak} + (RES_W+1)'(w_psum_rd);
  assign w_m       = w_m_wide[RES_W] ? RES_MAX : w_m_wide[RES_W-1:0];
  assign w_fire    = (w_m > THR);
  assign w_new_res = w_fire ? ((RESET_MODE != 0) ? '0 : (w_m - THR)) : w_m;

  // ---------------------------------------------------------------- storage
  // Data arrays carry no reset; validity lives in r_fill / r_res_vld, which do.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_psum_mem[w_wr_idx] <= in_psum;
    end
    if (w_hs) begin
      r_res_mem[RA_W'(r_spk_addr)] <= r_spk_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill    <= '0;
      r_res_vld <= '0;
      r_err_oor <= 1'b0;
    end else begin
      if (r_state == ST_DONE) begin
        r_fill    <= '0;
        r_res_vld <= '0;
      end else begin
        if (w_first) begin
          r_fill[w_wr_idx] <= 1'b1;
        end
        if (w_hs) begin
          r_res_vld[RA_W'(r_spk_addr)] <= 1'b1;
        end
      end
      if (w_accept && w_oor) begin
        r_err_oor <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_ts         <= '0;
      r_addr       <= '0;
      r_issued_all <= 1'b0;
      r_spk_valid  <= 1'b0;
      r_spk_data   <= 1'b0;
      r_spk_addr   <= '0;
      r_spk_ts     <= '0;
      r_spk_res    <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept && w_all_full) begin
            r_state      <= ST_FIRE;
            r_ts         <= '0;
            r_addr       <= '0;
            r_issued_all <= 1'b0;
          end
        end
        ST_FIRE: begin
          if (w_last_hs) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_COLLECT;
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase

      // Output register refills whenever it is empty or draining this cycle.
      if (w_issue) begin
        r_spk_valid <= 1'b1;
        r_spk_data  <= w_fire;
        r_spk_addr  <= r_addr;
        r_spk_ts    <= r_ts;
        r_spk_res   <= w_new_res;
        if (w_last_ptr) begin
          r_issued_all <= 1'b1;
        end else if (32'(r_addr) == DEPTH - 1) begin
          r_addr <= '0;
          r_ts   <= r_ts + TS_W'(1);
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end else if (w_hs) begin
        r_spk_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = (r_state == ST_COLLECT);
  assign frame_done = (r_state == ST_DONE);
  assign spk_valid  = r_spk_valid;
  assign spk_data   = r_spk_data;
  assign spk_addr   = r_spk_addr;
  assign spk_ts     = r_spk_ts;
  assign err_oor    = r_err_oor;

endmodule

// File: tb/tb_output_spike_accum.sv
// Directed bench for output_spike_accum: three instances (subtract, reset-to-zero, leak)
// share one stimulus stream and are checked against hand-computed spike patterns.
module tb_output_spike_accum;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
  localparam int NUM_TS = 2;
  localparam int TS_W   = 1;
  localparam int PSUM_W = 13;
  localparam int NRES   = NUM_TS * DEPTH;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              spk_ready = 1'b1;
  logic [TS_W-1:0]   in_ts     = '0;
  logic [ADDR_W-1:0] in_addr   = '0;
  logic [PSUM_W-1:0] in_psum   = '0;

  logic rdy_m, vld_m, dat_m, done_m, err_m;
  logic [ADDR_W-1:0] addr_m;
  logic [TS_W-1:0]   ts_m;
  logic rdy_r, vld_r, dat_r, done_r, err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [TS_W-1:0]   ts_r;
  logic rdy_l, vld_l, dat_l, done_l, err_l;
  logic [ADDR_W-1:0] addr_l;
  logic [TS_W-1:0]   ts_l;

  int total = 0;
  int bad   = 0;
  int p0 [DEPTH];
  int p1 [DEPTH];
  logic [NRES-1:0]   got_m, got_r, got_l;
  logic [ADDR_W-1:0] got_addr [NRES];
  logic [TS_W-1:0]   got_ts   [NRES];
  int n_got, done_cnt;

  always #5 clk = ~clk;

  output_spike_accum #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_TS(NUM_TS), .TS_W(TS_W),
    .PSUM_W(PSUM_W), .RES_W(14), .THRESHOLD(64), .RESET_MODE(0), .LEAK_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_ts(in_ts),
    .in_addr(in_addr), .in_psum(in_psum), .spk_valid(vld_m), .spk_ready(spk_ready),
    .spk_data(dat_m), .spk_addr(addr_m), .spk_ts(ts_m), .frame_done(done_m), .err_oor(err_m));

  output_spike_accum #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_TS(NUM_TS), .TS_W(TS_W),
    .PSUM_W(PSUM_W), .RES_W(14), .THRESHOLD(64), .RESET_MODE(1), .LEAK_SHIFT(0)) dut_rm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_r), .in_ts(in_ts),
    .in_addr(in_addr), .in_psum(in_psum), .spk_valid(vld_r), .spk_ready(spk_ready),
    .spk_data(dat_r), .spk_addr(addr_r), .spk_ts(ts_r), .frame_done(done_r), .err_oor(err_r));

  output_spike_accum #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_TS(NUM_TS), .TS_W(TS_W),
    .PSUM_W(PSUM_W), .RES_W(14), .THRESHOLD(64), .RESET_MODE(0), .LEAK_SHIFT(1)) dut_lk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l), .in_ts(in_ts),
    .in_addr(in_addr), .in_psum(in_psum), .spk_valid(vld_l), .spk_ready(spk_ready),
    .spk_data(dat_l), .spk_addr(addr_l), .spk_ts(ts_l), .frame_done(done_l), .err_oor(err_l));

  task automatic send(input int ts, input int addr, input int val);
    int n = 0;
    in_valid = 1'b1;
    in_ts    = TS_W'(ts);
    in_addr  = ADDR_W'(addr);
    in_psum  = PSUM_W'(val);
    while (!rdy_m && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (rdy_m !== 1'b1) begin
      bad++;
      $display("FAIL send_ready ts=%0d addr=%0d in_ready=%b want 1", ts, addr, rdy_m);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("write ts=%0d addr=%0d psum=%0d", ts, addr, val);
  endtask

  task automatic send_frame();
    for (int i = 0; i < DEPTH; i++) send(0, i, p0[i]);
    for (int i = 0; i < DEPTH; i++) send(1, i, p1[i]);
  endtask

  task automatic collect(input bit rnd);
    int cyc = 0;
    int tail = 0;
    bit stalled = 1'b0;
    logic pd = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    logic [TS_W-1:0] pt = '0;
    n_got = 0;
    done_cnt = 0;
    while ((n_got < NRES || tail < 4) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done_m) done_cnt++;
      if (stalled) begin
        total++;
        if (vld_m !== 1'b1 || dat_m !== pd || addr_m !== pa || ts_m !== pt) begin
          bad++;
          $display("FAIL stall_hold got v=%b d=%b a=%0d t=%0d want v=1 d=%b a=%0d t=%0d",
                   vld_m, dat_m, addr_m, ts_m, pd, pa, pt);
        end
      end
      stalled = 1'b0;
      if (vld_m) begin
        if (spk_ready) begin
          if (n_got < NRES) begin
            got_m[n_got]    = dat_m;
            got_r[n_got]    = dat_r;
            got_l[n_got]    = dat_l;
            got_addr[n_got] = addr_m;
            got_ts[n_got]   = ts_m;
            $display("result ts=%0d addr=%0d spk=%b spk_rm=%b spk_lk=%b",
                     ts_m, addr_m, dat_m, dat_r, dat_l);
          end
          n_got++;
        end else begin
          stalled = 1'b1;
          pd = dat_m;
          pa = addr_m;
          pt = ts_m;
        end
      end
      if (n_got >= NRES) tail++;
      @(posedge clk); #1;
      spk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    spk_ready = 1'b1;
    total++;
    if (n_got != NRES) begin
      bad++;
      $display("FAIL result_count got %0d want %0d", n_got, NRES);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL frame_done_pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rdy_m !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", rdy_m); end
    total++;
    if ({vld_m, dat_m, addr_m, ts_m, done_m, err_m} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%b a=%0d t=%0d fd=%b e=%b want all 0",
               vld_m, dat_m, addr_m, ts_m, done_m, err_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 70; p1[i] = 10; end
    send_frame();
    total++;
    if (rdy_m !== 1'b0 || vld_m !== 1'b0) begin
      bad++;
      $display("FAIL fire_entry got in_ready=%b spk_valid=%b want 0 0", rdy_m, vld_m);
    end
    @(posedge clk); #1;
    total++;
    if (vld_m !== 1'b1) begin bad++; $display("FAIL first_latency spk_valid=%b want 1", vld_m); end
    collect(1'b0);
    total++;
    if (got_m !== 8'b0000_1111) begin bad++; $display("FAIL basic_spikes got %b want 00001111", got_m); end
    for (int i = 0; i < NRES; i++) begin
      total++;
      if (got_addr[i] !== ADDR_W'(i % DEPTH) || got_ts[i] !== TS_W'(i / DEPTH)) begin
        bad++;
        $display("FAIL basic_order idx=%0d got ts=%0d addr=%0d want ts=%0d addr=%0d",
                 i, got_ts[i], got_addr[i], i / DEPTH, i % DEPTH);
      end
    end
    total++;
    if (rdy_m !== 1'b1) begin bad++; $display("FAIL back_to_collect in_ready=%b want 1", rdy_m); end
  endtask

  task automatic test_reset_mode();
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 100; p1[i] = 60; end
    send_frame();
    collect(1'b0);
    total++;
    if (got_r !== 8'b0000_1111) begin bad++; $display("FAIL resetmode_spikes got %b want 00001111", got_r); end
    total++;
    if (got_m !== 8'b1111_1111) begin bad++; $display("FAIL subtract_spikes got %b want 11111111", got_m); end
  endtask

  task automatic test_leak();
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 40; p1[i] = 50; end
    send_frame();
    collect(1'b0);
    total++;
    if (got_l !== 8'b1111_0000) begin bad++; $display("FAIL leak_spikes got %b want 11110000", got_l); end
    total++;
    if (got_m !== 8'b1111_0000) begin bad++; $display("FAIL noleak_spikes got %b want 11110000", got_m); end
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 40; p1[i] = 40; end
    send_frame();
    collect(1'b0);
    total++;
    if (got_l !== 8'b0000_0000) begin bad++; $display("FAIL leak_spikes2 got %b want 00000000", got_l); end
    total++;
    if (got_m !== 8'b1111_0000) begin bad++; $display("FAIL noleak_spikes2 got %b want 11110000", got_m); end
  endtask

  task automatic test_duplicate();
    send(0, 0, 0); send(0, 1, 0); send(0, 2, 5); send(0, 3, 0);
    send(1, 0, 0); send(1, 1, 0); send(1, 2, 0);
    send(0, 2, 80);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy_m !== 1'b1 || vld_m !== 1'b0) begin
      bad++;
      $display("FAIL dup_no_early_fire got in_ready=%b spk_valid=%b want 1 0", rdy_m, vld_m);
    end
    send(1, 3, 0);
    collect(1'b0);
    total++;
    if (got_m !== 8'b0000_0100) begin bad++; $display("FAIL dup_spikes got %b want 00000100", got_m); end
  endtask

  task automatic test_back_to_back();
    p0[0] = 70; p0[1] = 64; p0[2] = 65; p0[3] = 200;
    p1[0] = 0;  p1[1] = 1;  p1[2] = 0;  p1[3] = 64;
    send(0, DEPTH, 999);
    total++;
    if (err_m !== 1'b1) begin bad++; $display("FAIL err_oor got %b want 1", err_m); end
    for (int i = 0; i < DEPTH; i++) send(0, i, p0[i]);
    for (int i = 0; i < DEPTH - 1; i++) send(1, i, p1[i]);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy_m !== 1'b1 || vld_m !== 1'b0) begin
      bad++;
      $display("FAIL oor_no_fill got in_ready=%b spk_valid=%b want 1 0", rdy_m, vld_m);
    end
    send(1, DEPTH - 1, p1[DEPTH-1]);
    collect(1'b1);
    total++;
    if (got_m !== 8'b1010_1101) begin bad++; $display("FAIL stall_spikes got %b want 10101101", got_m); end
    for (int i = 0; i < NRES; i++) begin
      total++;
      if (got_addr[i] !== ADDR_W'(i % DEPTH) || got_ts[i] !== TS_W'(i / DEPTH)) begin
        bad++;
        $display("FAIL stall_order idx=%0d got ts=%0d addr=%0d want ts=%0d addr=%0d",
                 i, got_ts[i], got_addr[i], i / DEPTH, i % DEPTH);
      end
    end
    total++;
    if (err_m !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err_m); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 70; p1[i] = 10; end
    send_frame();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (vld_m !== 1'b1) begin bad++; $display("FAIL midfire_active spk_valid=%b want 1", vld_m); end
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy_m !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got %b want 1", rdy_m); end
    total++;
    if ({vld_m, dat_m, addr_m, ts_m, done_m, err_m} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got v=%b d=%b a=%0d t=%0d fd=%b e=%b want all 0",
               vld_m, dat_m, addr_m, ts_m, done_m, err_m);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-fire reset released");
    for (int i = 0; i < DEPTH; i++) begin p0[i] = 60; p1[i] = 0; end
    send_frame();
    collect(1'b0);
    total++;
    if (got_m !== 8'b0000_0000) begin bad++; $display("FAIL postreset_spikes got %b want 00000000", got_m); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mode();
    test_leak();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
